// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single register-file write port between three writeback
// requesters: 0 = ALU, 1 = memory load, 2 = audio sample loader.
// At most one write is granted per cycle and captured into a registered
// write port. Writes to registers in PROT_MASK are accepted and discarded.
// The aging logic for requesters 1 and 2 is built only when WB_AGING_EN is
// defined; without it, priority is strictly 0 > 1 > 2.
module regfile_wb_arbiter #(
  parameter int          MAX_WAIT  = 4,
  parameter logic [15:0] PROT_MASK = 16'hA000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic [2:0]  req_valid,
  output logic [2:0]  req_ready,
  input  logic [11:0] req_rd,
  input  logic [95:0] req_wd,
  output logic [3:0]  rf_rd,
  output logic [31:0] rf_wd,
  output logic        rf_we,
  output logic        drop,
  output logic [15:0] pending
);

  // Per-requester views of the packed request buses
  logic [3:0]  w_rd [3];
  logic [31:0] w_wd [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_req
      assign w_rd[gi] = req_rd[4*gi +: 4];
      assign w_wd[gi] = req_wd[32*gi +: 32];
    end
  endgenerate

  // Out-of-range MAX_WAIT values are not supported; this empty block only
  // marks such an elaboration in the hierarchy.
  generate
    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_max_wait_out_of_range
    end
  endgenerate

  logic       w_aged1;
  logic       w_aged2;
  logic [2:0] w_grant;

`ifdef WB_AGING_EN
  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

  logic [3:0] r_wait1;
  logic [3:0] r_wait2;

  // A counter that has reached MAX_WAIT promotes its requester, but only
  // while that requester is actually presenting a request.
  assign w_aged1 = req_valid[1] && (r_wait1 == LP_MAX_WAIT);
  assign w_aged2 = req_valid[2] && (r_wait2 == LP_MAX_WAIT);

  // Wait counters: count passed-over cycles, saturate, clear on grant or withdrawal, freeze on hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait1 <= 4'd0;
      r_wait2 <= 4'd0;
    end else if (!hold) begin
      if (!req_valid[1] || w_grant[1])
        r_wait1 <= 4'd0;
      else if (r_wait1 < LP_MAX_WAIT)
        r_wait1 <= r_wait1 + 4'd1;

      if (!req_valid[2] || w_grant[2])
        r_wait2 <= 4'd0;
      else if (r_wait2 < LP_MAX_WAIT)
        r_wait2 <= r_wait2 + 4'd1;
    end
  end
`else
  assign w_aged1 = 1'b0;
  assign w_aged2 = 1'b0;
`endif

  // Winner selection: aged requesters first (1 before 2), then fixed 0 > 1 > 2
  always_comb begin
    w_grant = 3'b000;
    if (!rst && !hold) begin
      if (w_aged1)
        w_grant = 3'b010;
      else if (w_aged2)
        w_grant = 3'b100;
      else if (req_valid[0])
        w_grant = 3'b001;
      else if (req_valid[1])
        w_grant = 3'b010;
      else if (req_valid[2])
        w_grant = 3'b100;
    end
  end

  assign req_ready = w_grant;

  // Data mux for the granted requester
  logic [3:0]  w_sel_rd;
  logic [31:0] w_sel_wd;
  logic        w_xfer;
  logic        w_prot;

  // Route the winner's address and data toward the output register
  always_comb begin
    w_sel_rd = 4'd0;
    w_sel_wd = 32'd0;
    for (int i = 0; i < 3; i++) begin
      if (w_grant[i]) begin
        w_sel_rd = w_rd[i];
        w_sel_wd = w_wd[i];
      end
    end
  end

  assign w_xfer = |w_grant;
  assign w_prot = PROT_MASK[w_sel_rd];

  logic [3:0]  r_rf_rd;
  logic [31:0] r_rf_wd;
  logic        r_rf_we;
  logic        r_drop;

  // Output write port: load on an unprotected transfer, pulse drop on a protected one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rf_rd <= 4'd0;
      r_rf_wd <= 32'd0;
      r_rf_we <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_rf_we <= 1'b0;
      r_drop  <= 1'b0;
      if (w_xfer) begin
        if (w_prot) begin
          r_drop <= 1'b1;
        end else begin
          r_rf_rd <= w_sel_rd;
          r_rf_wd <= w_sel_wd;
          r_rf_we <= 1'b1;
        end
      end
    end
  end

  assign rf_rd = r_rf_rd;
  assign rf_wd = r_rf_wd;
  assign rf_we = r_rf_we;
  assign drop  = r_drop;

  logic [15:0] w_pending;

  // Hazard mask: requested or in-flight destinations, never the hardwired registers
  always_comb begin
    w_pending = 16'd0;
    for (int i = 0; i < 3; i++) begin
      if (req_valid[i])
        w_pending = w_pending | (16'd1 << w_rd[i]);
    end
    if (r_rf_we)
      w_pending = w_pending | (16'd1 << r_rf_rd);
    w_pending = w_pending & ~PROT_MASK;
    if (rst)
      w_pending = 16'd0;
  end

  assign pending = w_pending;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter with an output scoreboard.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [11:0] req_rd;
  logic [95:0] req_wd;
  logic [3:0]  rf_rd;
  logic [31:0] rf_wd;
  logic        rf_we;
  logic        drop;
  logic [15:0] pending;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.MAX_WAIT(4), .PROT_MASK(16'hA000)) dut (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rd    (req_rd),
    .req_wd    (req_wd),
    .rf_rd     (rf_rd),
    .rf_wd     (rf_wd),
    .rf_we     (rf_we),
    .drop      (drop),
    .pending   (pending)
  );

  typedef struct packed {
    logic        we;
    logic        dr;
    logic [3:0]  rd;
    logic [31:0] wd;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic we, input logic dr, input logic [3:0] rd, input logic [31:0] wd);
    exp_t e;
    e.we = we;
    e.dr = dr;
    e.rd = rd;
    e.wd = wd;
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: every write or drop pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst === 1'b0 && (rf_we === 1'b1 || drop === 1'b1)) begin
      if (q.size() == 0) begin
        chk("unexpected_output", {26'd0, rf_we, drop, rf_rd, rf_wd}, 64'd0);
      end else begin
        mon_e = q.pop_front();
        chk("rf_out", {26'd0, rf_we, drop, rf_rd, rf_wd}, {26'd0, mon_e});
        $display("[TB] out we=%0b drop=%0b rd=%0d wd=%h", rf_we, drop, rf_rd, rf_wd);
      end
    end
  end

  initial begin
    logic [2:0]  exp_g;
    logic [31:0] wd0;
    int          aging;
`ifdef WB_AGING_EN
    aging = 1;
`else
    aging = 0;
`endif
    rst = 1'b1; hold = 1'b0; req_valid = 3'b000; req_rd = 12'd0; req_wd = 96'd0;

    // Reset state
    #1;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_drop", drop, 0);
    chk("rst_rf_rd", rf_rd, 0);
    chk("rst_rf_wd", rf_wd, 0);
    chk("rst_pending", pending, 0);
    req_valid = 3'b001; req_rd[3:0] = 4'd4;
    #1;
    chk("rst_ready", req_ready, 3'b000);
    chk("rst_pending_req", pending, 0);
    req_valid = 3'b000;
    cyc();
    rst = 1'b0;

    // Single write
    req_valid = 3'b001; req_rd[3:0] = 4'd4; req_wd[31:0] = 32'hDEADBEEF;
    #1;
    chk("single_ready", req_ready, 3'b001);
    chk("single_pend_req", pending, 16'h0010);
    $display("[TB] single write rd=4 wd=DEADBEEF");
    push(1, 0, 4'd4, 32'hDEADBEEF);
    cyc();
    req_valid = 3'b000;
    #1;
    chk("single_we", rf_we, 1);
    chk("single_pend_fly", pending, 16'h0010);
    cyc();
    chk("single_pend_done", pending, 16'h0000);

    // Collision: three requesters at once
    req_valid = 3'b111;
    req_rd = {4'd3, 4'd2, 4'd1};
    req_wd = {32'hA3, 32'hA2, 32'hA1};
    #1;
    chk("coll_ready0", req_ready, 3'b001);
    chk("coll_pend", pending, 16'h000E);
    $display("[TB] collision rd=1/2/3");
    push(1, 0, 4'd1, 32'hA1);
    push(1, 0, 4'd2, 32'hA2);
    push(1, 0, 4'd3, 32'hA3);
    cyc();
    req_valid = 3'b110;
    #1;
    chk("coll_ready1", req_ready, 3'b010);
    cyc();
    req_valid = 3'b100;
    #1;
    chk("coll_ready2", req_ready, 3'b100);
    cyc();
    req_valid = 3'b000;
    cyc();

    // Protected writes: R13 then R15, rf_rd/rf_wd must keep rd=3, wd=A3
    req_valid = 3'b010; req_rd[7:4] = 4'd13; req_wd[63:32] = 32'h1234;
    #1;
    chk("prot13_ready", req_ready, 3'b010);
    chk("prot13_pend", pending, 16'h0000);
    $display("[TB] protected write rd=13");
    push(0, 1, 4'd3, 32'hA3);
    cyc();
    req_rd[7:4] = 4'd15; req_wd[63:32] = 32'h5678;
    #1;
    chk("prot15_ready", req_ready, 3'b010);
    chk("prot13_drop", drop, 1);
    chk("prot15_pend", pending, 16'h0000);
    $display("[TB] protected write rd=15");
    push(0, 1, 4'd3, 32'hA3);
    cyc();
    req_valid = 3'b000;
    cyc();

    // Hold: in-flight write still issues, new grants blocked for 3 cycles
    req_valid = 3'b001; req_rd[3:0] = 4'd5; req_wd[31:0] = 32'h55;
    #1;
    chk("hold_pre_ready", req_ready, 3'b001);
    push(1, 0, 4'd5, 32'h55);
    cyc();
    hold = 1'b1; req_rd[3:0] = 4'd7; req_wd[31:0] = 32'h77;
    #1;
    chk("hold_inflight_we", rf_we, 1);
    chk("hold_pend", pending, 16'h00A0);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("hold_ready_c%0d", c), req_ready, 3'b000);
      $display("[TB] hold cycle %0d", c);
      cyc();
    end
    hold = 1'b0;
    #1;
    chk("hold_release_ready", req_ready, 3'b001);
    push(1, 0, 4'd7, 32'h77);
    cyc();
    req_valid = 3'b000;
    cyc();

    // Aging: requester 0 streams while requester 2 waits
    req_valid = 3'b101;
    req_rd[3:0] = 4'd6; wd0 = 32'h0600_0001; req_wd[31:0] = wd0;
    req_rd[11:8] = 4'd9; req_wd[95:64] = 32'h0900_0009;
    for (int c = 1; c <= 6; c++) begin
      exp_g = (aging == 1 && c == 5) ? 3'b100 : 3'b001;
      #1;
      chk($sformatf("age_ready_c%0d", c), req_ready, exp_g);
      $display("[TB] aging cycle %0d ready=%b", c, req_ready);
      if (exp_g == 3'b001) push(1, 0, 4'd6, wd0);
      else                 push(1, 0, 4'd9, 32'h0900_0009);
      cyc();
      if (exp_g == 3'b001) begin
        wd0 = wd0 + 32'd1;
        req_wd[31:0] = wd0;
      end else begin
        req_valid[2] = 1'b0;
      end
    end
    req_valid[0] = 1'b0;
    if (req_valid[2]) begin
      #1;
      chk("age_starved_ready", req_ready, 3'b100);
      push(1, 0, 4'd9, 32'h0900_0009);
      cyc();
      req_valid[2] = 1'b0;
    end
    cyc();

    // Asynchronous reset while a write sits in the output register
    req_valid = 3'b001; req_rd[3:0] = 4'd8; req_wd[31:0] = 32'h88;
    #1;
    chk("arst_pre_ready", req_ready, 3'b001);
    cyc();
    #1;
    chk("arst_pre_we", rf_we, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_we", rf_we, 0);
    chk("arst_drop", drop, 0);
    chk("arst_pend", pending, 0);
    chk("arst_ready", req_ready, 0);
    chk("arst_rf_rd", rf_rd, 0);
    $display("[TB] async reset mid-write");
    cyc();
    rst = 1'b0;
    #1;
    chk("arst_re_ready", req_ready, 3'b001);
    push(1, 0, 4'd8, 32'h88);
    cyc();
    req_valid = 3'b000;
    cyc();
    cyc();

    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
